// File: rtl/alu_pkg.sv
// Shared width, flag bit positions and the packed status-flag type for the
// alu16 adder/status stage.
package alu_pkg;

    localparam int ALU_W = 16;

    localparam int FLG_S = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_C = 2;
    localparam int FLG_P = 3;
    localparam int FLG_V = 4;

    // Fields are declared MSB-first so that each one sits at its FLG_* bit index.
    typedef struct packed {
        logic v;
        logic p;
        logic c;
        logic z;
        logic s;
    } alu_flags_t;

endpackage

// File: rtl/alu16_if.sv
// Operand/result bundle for alu16: the master drives operands and receives the
// registered sum and flags.
interface alu16_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic [WIDTH-1:0] z;
    logic             sign;
    logic             zero;
    logic             carry;
    logic             parity;
    logic             overflow;

    modport master (
        output in_valid, x, y,
        input  out_valid, z, sign, zero, carry, parity, overflow
    );

    modport slave (
        input  in_valid, x, y,
        output out_valid, z, sign, zero, carry, parity, overflow
    );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational status-flag derivation from one transaction's operands and its
// WIDTH+1-bit sum.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH:0]   sum,
    output alu_flags_t       flags
);

    logic [WIDTH-1:0] res;

    assign res = sum[WIDTH-1:0];

    always_comb begin
        flags   = '0;
        flags.s = res[WIDTH-1];
        flags.z = (res == '0);
        flags.c = sum[WIDTH];
        // Even parity: set when the population count of the result is even.
        flags.p = ~(^res);
        flags.v = (x[WIDTH-1] == y[WIDTH-1]) && (res[WIDTH-1] != x[WIDTH-1]);
    end

endmodule

// File: rtl/alu16.sv
// Registered WIDTH-bit adder with sign/zero/carry/parity/overflow status; the
// result and flags of an accepted transaction appear one clock later.
module alu16
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic         clk,
    input  logic         rst_n,
    alu16_if.slave       bus
);

    logic [WIDTH:0]   sum_p0;
    alu_flags_t       flags_p0;

    logic [WIDTH-1:0] z_p1;
    alu_flags_t       flags_p1;
    logic             vld_p1;

    assign sum_p0 = {1'b0, bus.x} + {1'b0, bus.y};

    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .x     (bus.x),
        .y     (bus.y),
        .sum   (sum_p0),
        .flags (flags_p0)
    );

    // p0 -> p1: result and flags are captured together so they never mix
    // transactions; an idle cycle leaves them holding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            z_p1     <= '0;
            flags_p1 <= '0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                z_p1     <= sum_p0[WIDTH-1:0];
                flags_p1 <= flags_p0;
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.z         = z_p1;
    assign bus.sign      = flags_p1.s;
    assign bus.zero      = flags_p1.z;
    assign bus.carry     = flags_p1.c;
    assign bus.parity    = flags_p1.p;
    assign bus.overflow  = flags_p1.v;

endmodule

// File: tb/tb_alu16.sv
// Directed bench for alu16: hand-computed vectors plus an arithmetic reference
// model compared against the outputs on every falling edge.
module tb_alu16;

    logic clk;
    logic rst_n;

    alu16_if #(.WIDTH(16)) bus ();

    alu16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operands.
    logic        m_vld;
    logic [15:0] m_z;
    logic [4:0]  m_f;   // {s, z, c, p, v}

    function automatic void ref_add(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] rz, output logic [4:0] rf);
        int u;
        int sa;
        int sb;
        int ss;
        u  = int'(a) + int'(b);
        sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
        sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
        ss = sa + sb;
        rz = 16'(u % 65536);
        rf[4] = (rz >= 16'h8000);
        rf[3] = (u % 65536 == 0);
        rf[2] = (u >= 65536);
        rf[1] = ($countones(rz) % 2 == 0);
        rf[0] = (ss > 32767) || (ss < -32768);
    endfunction

    always @(posedge clk) begin
        logic [15:0] nz;
        logic [4:0]  nf;
        if (!rst_n) begin
            m_vld <= 1'b0;
            m_z   <= 16'h0000;
            m_f   <= 5'b00000;
        end else begin
            m_vld <= bus.in_valid;
            if (bus.in_valid) begin
                ref_add(bus.x, bus.y, nz, nf);
                m_z <= nz;
                m_f <= nf;
            end
        end
    end

    function automatic logic [4:0] act_flags();
        return {bus.sign, bus.zero, bus.carry, bus.parity, bus.overflow};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (bus.out_valid !== m_vld || bus.z !== m_z || act_flags() !== m_f) begin
                n_fail++;
                $display("FAIL model t=%0t: got vld=%b z=%h f=%b, want vld=%b z=%h f=%b",
                         $time, bus.out_valid, bus.z, act_flags(), m_vld, m_z, m_f);
            end
        end
    end

    task automatic check(input string name, input logic ev, input logic [15:0] ez,
                         input logic [4:0] ef);
        n_tests++;
        if (bus.out_valid !== ev || bus.z !== ez || act_flags() !== ef) begin
            n_fail++;
            $display("FAIL %s: got vld=%b z=%h f=%b, want vld=%b z=%h f=%b",
                     name, bus.out_valid, bus.z, act_flags(), ev, ez, ef);
        end
    endtask

    // Drive one operand pair, let it be sampled, then check the literal result.
    task automatic vec(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ez, input logic [4:0] ef);
        bus.in_valid = 1'b1;
        bus.x        = a;
        bus.y        = b;
        @(posedge clk);
        #1;
        check(name, 1'b1, ez, ef);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.x        = 16'h1234;
        bus.y        = 16'h1111;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        check("reset", 1'b0, 16'h0000, 5'b00000);

        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset", 1'b1, 16'h2345, 5'b00010);

        vec("ovf_carry",   16'h8FFF, 16'h8000, 16'h0FFF, 5'b00111);
        vec("carry_zero",  16'hFFFE, 16'h0002, 16'h0000, 5'b01110);
        vec("wrap_ffff",   16'hFFFF, 16'h0001, 16'h0000, 5'b01110);
        vec("pattern",     16'hAAAA, 16'h5555, 16'hFFFF, 5'b10010);

        bus.in_valid = 1'b0;
        bus.x        = 16'h0005;
        bus.y        = 16'h0005;
        @(posedge clk);
        #1;
        check("idle_hold", 1'b0, 16'hFFFF, 5'b10010);

        vec("pos_ovf",     16'h7FFF, 16'h0001, 16'h8000, 5'b10001);
        vec("odd_parity",  16'h0001, 16'h0000, 16'h0001, 5'b00000);
        vec("carry_only",  16'hFFFF, 16'hFFFF, 16'hFFFE, 5'b10100);
        vec("neg_plus",    16'h8000, 16'h0001, 16'h8001, 5'b10010);

        // Reset in the middle of a stream drops the pending transaction.
        bus.x        = 16'h1234;
        bus.y        = 16'h1111;
        bus.in_valid = 1'b1;
        rst_n        = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset", 1'b0, 16'h0000, 5'b00000);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            bus.in_valid = (i % 5 != 3);
            bus.x        = 16'($urandom);
            bus.y        = 16'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu16.md
# alu16

16-bit registered adder ALU with a five-flag status output (sign, zero, carry, parity, overflow). It computes z = x + y each accepted cycle and presents the result and flags one clock later. It serves as the arithmetic/status stage for datapath blocks that need a sum plus condition codes.

## Interface
- WIDTH, 16, operand/result width; flags are defined for any WIDTH ≥ 2, and verification targets 16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  x/y valid this cycle.
- x  in  WIDTH  operand A, two's complement or unsigned.
- y  in  WIDTH  operand B.
- out_valid  out  1  z/flags updated by previous-cycle accepted operands.
- z  out  WIDTH  result x + y mod 2^WIDTH.
- sign  out  1  z[WIDTH-1].
- zero  out  1  1 when z == 0.
- carry  out  1  unsigned carry-out of bit WIDTH-1.
- parity  out  1  even-parity flag: 1 when popcount(z) is even (all WIDTH bits).
- overflow  out  1  signed overflow: x[MSB] == y[MSB] and z[MSB] != x[MSB].

## Operation
- Sum formed as a WIDTH+1-bit add. z is the low WIDTH bits and carry is bit WIDTH.
- Flags are derived from the computed sum and operands of the same transaction. They are never mixed across transactions.
- in_valid=1: on the clock edge, register z and all flags, and set out_valid=1.
- in_valid=0: z and flags hold their last value, and out_valid=0 next cycle.
- No operation select; addition only. There is no carry-in.
- Full wrap-around is required. Examples:
  - 0xFFFF + 0x0001 gives z=0x0000, carry=1, zero=1.
  - 0x7FFF + 0x0001 gives z=0x8000, overflow=1, sign=1, carry=0.
- carry and overflow are independent. All four combinations must be reachable.

## Timing
- Latency is exactly 1 cycle: operands sampled at edge N appear on the outputs after edge N.
- Throughput is one transaction per cycle. There is no backpressure.
- Reset (rst_n=0 at an edge): z=0, sign=0, zero=0, carry=0, parity=0, overflow=0, out_valid=0.
  - Flags reset to 0 even though z=0; they are not computed from the reset value.
- Reset overrides in_valid on the same edge. The transaction is dropped.
- First valid output comes 1 cycle after the first accepted in_valid following reset release.
- Reset asserted mid-stream drops any pending result.
- Outputs are glitch-free registers. There are no combinational paths from inputs to outputs.

## Structure
- Package alu_pkg holds:
  - localparam ALU_W = 16;
  - flag index constants FLG_S=0, FLG_Z=1, FLG_C=2, FLG_P=3, FLG_V=4;
  - a packed struct alu_flags_t {s, z, c, p, v}.
- One combinational sub-module, alu_flag_gen:
  - inputs: x, y, the WIDTH+1-bit sum;
  - output: alu_flags_t.
- The top-level alu16 instantiates alu_flag_gen plus the output register and valid register.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, x=0x1234, y=0x1111 -> all outputs 0 and out_valid=0. First result z=0x2345 appears 1 cycle after release.
- Signed overflow with carry: x=0x8FFF, y=0x8000 -> z=0x0FFF, sign=0, zero=0, carry=1, parity=1, overflow=1.
- Carry to zero: x=0xFFFE, y=0x0002 -> z=0x0000, sign=0, zero=1, carry=1, parity=1, overflow=0.
- Bit pattern: x=0xAAAA, y=0x5555 -> z=0xFFFF, sign=1, zero=0, carry=0, parity=1, overflow=0.
- Positive overflow and odd parity:
  - x=0x7FFF, y=0x0001 -> z=0x8000, sign=1, carry=0, overflow=1, parity=0.
  - then x=0x0001, y=0x0000 -> z=0x0001, parity=0, all other flags 0.
- Hold/throughput:
  - back-to-back valid pairs produce results on consecutive cycles;
  - a cycle with in_valid=0 keeps z/flags unchanged and gives out_valid=0 one cycle later.
